branch_resolution_unit: RTL and testbench

BRANCH_RESOLUTION_UNIT -- requirements
Module: branch_resolution_unit

---
 rtl/branch_resolution_unit.sv | 136 +++++++++++++
 tb/tb_branch_resolution_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: in-order prediction queue, resolve/compare against actual
// outcome, predictor update and mispredict redirect, with a RUN/FLUSH recovery FSM.
module branch_resolution_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        predict_valid,
  input  logic [7:0]  predict_pc,
  input  logic        predict_taken,
  input  logic [7:0]  predict_target,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  input  logic [7:0]  resolve_target,
  output logic        update_valid,
  output logic [7:0]  update_pc,
  output logic        update_taken,
  output logic [7:0]  update_target,
  output logic        mispredict,
  output logic [7:0]  redirect_pc,
  output logic        busy,
  output logic        queue_full,
  output logic        queue_empty,
  output logic        overflow_err,
  output logic        underflow_err,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [7:0] pc;
    logic       taken;
    logic [7:0] target;
  } entry_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t          r_state;
  logic [3:0]      r_flush_cnt;
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  entry_t          r_mem [DEPTH];

  entry_t          w_head;
  logic            w_run, w_deq, w_enq, w_mis;

  assign w_head      = r_mem[r_rptr];
  assign w_run       = (r_state == RUN);
  assign queue_full  = (r_count == CW'(DEPTH));
  assign queue_empty = (r_count == '0);
  assign busy        = (r_state == FLUSH);

  assign w_deq = resolve_valid && w_run && !queue_empty;
  assign w_enq = predict_valid && w_run && (!queue_full || w_deq);
  assign w_mis = w_deq && ((w_head.taken != resolve_taken) ||
                 (w_head.taken && resolve_taken && (w_head.target != resolve_target)));

  // Storage is only read while count>0, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_enq && !w_mis) r_mem[r_wptr] <= '{pc: predict_pc, taken: predict_taken,
                                            target: predict_target};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_mis) begin
      // Wrong path: drop everything in flight, including a same-cycle enqueue.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= PW'(r_wptr + 1'b1);
      if (w_deq) r_rptr <= PW'(r_rptr + 1'b1);
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        RUN: if (w_mis) begin
          r_state     <= FLUSH;
          r_flush_cnt <= 4'(FLUSH_CYCLES);
        end
        FLUSH: begin
          if (r_flush_cnt <= 4'd1) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_valid     <= 1'b0;
      update_pc        <= '0;
      update_taken     <= 1'b0;
      update_target    <= '0;
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      overflow_err     <= 1'b0;
      underflow_err    <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      update_valid <= w_deq;
      mispredict   <= w_mis;
      if (w_deq) begin
        update_pc     <= w_head.pc;
        update_taken  <= resolve_taken;
        update_target <= resolve_target;
        if (branch_count != 16'hFFFF) branch_count <= branch_count + 16'd1;
      end
      if (w_mis) begin
        redirect_pc <= resolve_taken ? resolve_target : w_head.pc + 8'd1;
        if (mispredict_count != 16'hFFFF) mispredict_count <= mispredict_count + 16'd1;
      end
      if (predict_valid && w_run && queue_full && !w_deq) overflow_err  <= 1'b1;
      if (resolve_valid && w_run && queue_empty)           underflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolution_unit.sv
// Randomized + directed bench for branch_resolution_unit against a queue-based model.
module tb_branch_resolution_unit;
  localparam int DEPTH = 4;
  localparam int FLUSH_CYCLES = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic pv = 0, pt = 0, rv = 0, rt = 0;
  logic [7:0] ppc = 0, ptg = 0, rtg = 0;
  logic        update_valid, update_taken, mispredict, busy;
  logic        queue_full, queue_empty, overflow_err, underflow_err;
  logic [7:0]  update_pc, update_target, redirect_pc;
  logic [15:0] branch_count, mispredict_count;

  branch_resolution_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .predict_valid(pv), .predict_pc(ppc), .predict_taken(pt), .predict_target(ptg),
    .resolve_valid(rv), .resolve_taken(rt), .resolve_target(rtg),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .busy(busy), .queue_full(queue_full), .queue_empty(queue_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .branch_count(branch_count), .mispredict_count(mispredict_count));

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] pc; logic taken; logic [7:0] tgt;} ent_t;

  ent_t q[$];
  int   flush_left, m_bc, m_mc;
  bit   m_ovf, m_uf, e_uv, e_mp, e_tk;
  logic [7:0] e_pc, e_tg, e_rd;
  int   n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); flush_left = 0; m_bc = 0; m_mc = 0;
    m_ovf = 0; m_uf = 0; e_uv = 0; e_mp = 0;
  endtask

  // Behavioural model of one clock edge, using the inputs currently driven.
  task automatic model_step();
    ent_t e;
    bit deq, enq, mis;
    e_uv = 0; e_mp = 0; mis = 0;
    if (flush_left > 0) begin
      flush_left--;
      return;
    end
    deq = rv && q.size() > 0;
    if (rv && q.size() == 0) m_uf = 1;
    enq = pv && (q.size() < DEPTH || deq);
    if (pv && !enq) m_ovf = 1;
    if (deq) begin
      e = q.pop_front();
      mis = (e.taken != rt) || (e.taken && rt && e.tgt != rtg);
      e_uv = 1; e_pc = e.pc; e_tk = rt; e_tg = rtg;
      if (m_bc < 65535) m_bc++;
      if (mis) begin
        e_mp = 1;
        e_rd = rt ? rtg : 8'((int'(e.pc) + 1) % 256);
        if (m_mc < 65535) m_mc++;
        q.delete();
        flush_left = FLUSH_CYCLES;
      end
    end
    if (enq && !mis) q.push_back('{pc: ppc, taken: pt, tgt: ptg});
  endtask

  task automatic check_all();
    chk("update_valid", update_valid, e_uv);
    if (e_uv) begin
      chk("update_pc", update_pc, e_pc);
      chk("update_taken", update_taken, e_tk);
      chk("update_target", update_target, e_tg);
    end
    chk("mispredict", mispredict, e_mp);
    if (e_mp) chk("redirect_pc", redirect_pc, e_rd);
    chk("busy", busy, flush_left > 0);
    chk("queue_full", queue_full, q.size() == DEPTH);
    chk("queue_empty", queue_empty, q.size() == 0);
    chk("overflow_err", overflow_err, m_ovf);
    chk("underflow_err", underflow_err, m_uf);
    chk("branch_count", branch_count, m_bc);
    chk("mispredict_count", mispredict_count, m_mc);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic p_v, input logic [7:0] p_pc, input logic p_t,
                       input logic [7:0] p_tg, input logic r_v, input logic r_t,
                       input logic [7:0] r_tg);
    pv = p_v; ppc = p_pc; pt = p_t; ptg = p_tg; rv = r_v; rt = r_t; rtg = r_tg;
    tick();
  endtask

  task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0); endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_update_valid", update_valid, 0);
    chk("rst_update_pc", update_pc, 0);
    chk("rst_update_target", update_target, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_busy", busy, 0);
    chk("rst_queue_empty", queue_empty, 1);
    chk("rst_queue_full", queue_full, 0);
    chk("rst_errors", {overflow_err, underflow_err}, 0);
    chk("rst_counts", {branch_count, mispredict_count}, 0);
    #2;
    rst_n = 1;
  endtask

  initial begin
    #2;
    do_reset();
    @(posedge clk); #1;

    // Correct taken prediction.
    drive(1, 8'h10, 1, 8'h40, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 8'h40);
    chk("d41_pc", update_pc, 8'h10);
    chk("d41_bc", branch_count, 1);

    // Direction mispredict with PC wrap, younger entries flushed.
    drive(1, 8'hFF, 1, 8'h20, 0, 0, 0);
    drive(1, 8'h01, 0, 8'h00, 0, 0, 0);
    drive(1, 8'h02, 1, 8'h50, 0, 0, 0);
    drive(1, 8'h03, 0, 8'h00, 1, 0, 8'h77);
    chk("d42_redirect", redirect_pc, 8'h00);
    chk("d42_busy0", busy, 1);
    drive(1, 8'h04, 1, 8'h10, 1, 1, 8'h10);
    chk("d42_busy1", busy, 1);
    idle();
    chk("d42_run", busy, 0);
    chk("d42_empty", queue_empty, 1);

    // Target mispredict.
    drive(1, 8'h08, 1, 8'h30, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 8'h31);
    chk("d43_redirect", redirect_pc, 8'h31);
    idle(); idle();

    // Overflow, then full-queue enqueue+dequeue keeps order.
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(8'hA0 + i), 0, 0, 0, 0, 0);
    drive(1, 8'hB0, 0, 0, 0, 0, 0);
    chk("d44_ovf", overflow_err, 1);
    drive(1, 8'hA4, 0, 0, 1, 0, 8'h00);
    chk("d44_full", queue_full, 1);
    for (int i = 1; i <= DEPTH; i++) begin
      drive(0, 0, 0, 0, 1, 0, 8'h00);
      chk("d44_order", update_pc, 8'(8'hA0 + i));
    end

    // Underflow, then reset in the middle of FLUSH.
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("d45_uf", underflow_err, 1);
    drive(1, 8'h20, 0, 0, 0, 0, 0);
    drive(1, 8'h21, 0, 0, 1, 1, 8'h99);
    do_reset();
    idle();
    chk("d45_no_upd", update_valid, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic r_v, r_t;
      logic [7:0] r_tg;
      r_v = ($urandom_range(0, 2) == 0);
      r_t = 1'($urandom); r_tg = 8'($urandom_range(0, 3));
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        r_t = q[0].taken;
        r_tg = q[0].taken ? q[0].tgt : 8'($urandom);
      end
      drive(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom),
            8'($urandom_range(0, 3)), r_v, r_t, r_tg);
    end

    // Drive branch_count into saturation with correct taken predictions.
    while (flush_left > 0) idle();
    while (q.size() > 0) drive(0, 0, 0, 0, 1, q[0].taken, q[0].tgt);
    drive(1, 8'h33, 1, 8'h55, 0, 0, 0);
    for (int n = 0; n < 65540; n++) drive(1, 8'h33, 1, 8'h55, 1, 1, 8'h55);
    chk("d46_sat", branch_count, 16'hFFFF);
    drive(0, 0, 0, 0, 1, 1, 8'h55);
    chk("d46_sat_hold", branch_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
